// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle RV32I-subset control path.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JAL_PC,
        S_LUI,
        S_FAULT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b101,
        ALU_PASSB = 3'b110
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder for R-type and I-type arithmetic.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_is_r,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);

    // Map funct3/funct7_5 onto the supported ops; anything else is illegal.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (funct3)
            3'b000:  alu_ctrl = (op_is_r && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: illegal  = 1'b1;
        endcase
        // R-type only defines funct7_5 for add/sub; I-type ignores it.
        if (op_is_r && funct7_5 && funct3 != 3'b000) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I-subset datapath with memory wait timeout.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [2:0] ALUctrl,
    output logic [2:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic       fault,
    output logic       retire
);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [2:0] dec_ctrl;
    logic       dec_illegal;
    logic       wait_expired;
    logic       branch_ok;

    alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .op_is_r  (state == S_EXEC_R),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal)
    );

    // The last permitted cycle without mem_ready; mem_ready in that cycle still wins.
    assign wait_expired = (wait_cnt == 8'(MEM_WAIT_MAX - 1)) && !mem_ready;
    assign branch_ok    = (funct3[2:1] == 2'b00);

    // State register and wait counter; the counter restarts whenever a wait state is left or entered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (mem_ready) begin
                        state <= (state == S_FETCH)  ? S_DECODE :
                                 (state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                    end else if (wait_expired) begin
                        state <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_R:              state <= S_EXEC_R;
                        OP_I:              state <= S_EXEC_I;
                        OP_LOAD, OP_STORE: state <= S_MEM_ADR;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
                        OP_LUI:            state <= S_LUI;
                        default:           state <= S_FAULT;
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state <= dec_illegal ? S_FAULT : S_ALU_WB;
                S_MEM_ADR: begin
                    if (funct3 != 3'b010) state <= S_FAULT;
                    else                  state <= (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_BRANCH:                   state <= branch_ok ? S_FETCH : S_FAULT;
                S_JAL:                      state <= S_JAL_PC;
                S_ALU_WB, S_MEM_WB,
                S_JAL_PC, S_LUI:            state <= S_FETCH;
                S_FAULT:                    state <= S_FAULT;
                default:                    state <= S_FAULT;
            endcase
        end
    end

    // Output decode: Moore on state, plus mem_ready in FETCH and Zero/funct3 in BRANCH.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUsrcA   = SRCA_PC;
        ALUsrcB   = SRCB_RS2;
        ALUctrl   = ALU_ADD;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALUOUT;
        fault     = 1'b0;
        retire    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUsrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUsrcA = SRCA_OLDPC;
                    ALUsrcB = SRCB_IMM;
                    ImmSrc  = IMM_B;
                end
                S_EXEC_R: begin
                    ALUsrcA = SRCA_RS1;
                    ALUctrl = dec_ctrl;
                end
                S_EXEC_I: begin
                    ALUsrcA = SRCA_RS1;
                    ALUsrcB = SRCB_IMM;
                    ALUctrl = dec_ctrl;
                end
                S_ALU_WB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MEM_ADR: begin
                    ALUsrcA = SRCA_RS1;
                    ALUsrcB = SRCB_IMM;
                    ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_MEM;
                    retire    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    AdrSrc  = 1'b1;
                    retire  = mem_ready;
                end
                S_BRANCH: begin
                    ALUsrcA = SRCA_RS1;
                    ALUctrl = ALU_SUB;
                    PCWrite = branch_ok && (Zero ^ funct3[0]);
                    retire  = branch_ok;
                end
                S_JAL: begin
                    ALUsrcA   = SRCA_OLDPC;
                    ALUsrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    RegWrite  = 1'b1;
                end
                S_JAL_PC: begin
                    ALUsrcA   = SRCA_OLDPC;
                    ALUsrcB   = SRCB_IMM;
                    ImmSrc    = IMM_J;
                    ResultSrc = RES_ALU;
                    PCWrite   = 1'b1;
                    retire    = 1'b1;
                end
                S_LUI: begin
                    ALUsrcB   = SRCB_IMM;
                    ALUctrl   = ALU_PASSB;
                    ImmSrc    = IMM_U;
                    ResultSrc = RES_ALU;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                S_FAULT: fault = 1'b1;
                default: fault = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_WAIT_MAX = 4).
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUsrcA, ALUsrcB, ResultSrc;
    logic [2:0] ALUctrl, ImmSrc;
    logic       fault, retire;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .ALUsrcA   (ALUsrcA),
        .ALUsrcB   (ALUsrcB),
        .ALUctrl   (ALUctrl),
        .ImmSrc    (ImmSrc),
        .ResultSrc (ResultSrc),
        .fault     (fault),
        .retire    (retire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    // Run one R/I arithmetic instruction from FETCH back to FETCH (zero-wait memory).
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [2:0] exp_ctrl);
        set_instr(op, f3, f7);
        check({tag, "_fetch_req"}, mem_req, 1);
        cyc();
        check({tag, "_dec_srca"}, ALUsrcA, 2'b01);
        cyc();
        check({tag, "_exec_ctrl"}, ALUctrl, exp_ctrl);
        check({tag, "_exec_srcb"}, ALUsrcB, (op == 7'b0110011) ? 2'b00 : 2'b01);
        check({tag, "_exec_nowr"}, RegWrite, 0);
        cyc();
        check({tag, "_wb_regwrite"}, RegWrite, 1);
        check({tag, "_wb_retire"}, retire, 1);
        check({tag, "_wb_ressrc"}, ResultSrc, 2'b00);
        cyc();
        check({tag, "_back_fetch"}, mem_req, 1);
        check({tag, "_back_retire"}, retire, 0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        Zero      = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);

        // Reset: all strobes low while rst is high.
        cyc();
        check("rst_mem_req", mem_req, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_fault", fault, 0);
        cyc();
        rst = 1'b0;
        #1;

        // First post-reset cycle: FETCH with mem_ready already high.
        check("fetch0_mem_req", mem_req, 1);
        check("fetch0_adrsrc", AdrSrc, 0);
        check("fetch0_irwrite", IRWrite, 1);
        check("fetch0_pcwrite", PCWrite, 1);
        check("fetch0_srcb", ALUsrcB, 2'b10);
        check("fetch0_ressrc", ResultSrc, 2'b10);
        cyc();
        check("decode_mem_req", mem_req, 0);
        check("decode_srcb", ALUsrcB, 2'b01);
        check("decode_immsrc", ImmSrc, 3'b010);
        check("decode_irwrite", IRWrite, 0);
        cyc();  // EXEC_R
        check("add_exec_ctrl", ALUctrl, 3'b000);
        check("add_exec_srca", ALUsrcA, 2'b10);
        cyc();  // ALU_WB
        check("add_wb_regwrite", RegWrite, 1);
        check("add_wb_retire", retire, 1);
        cyc();  // FETCH

        run_alu("sub", 7'b0110011, 3'b000, 1'b1, 3'b001);
        run_alu("and", 7'b0110011, 3'b111, 1'b0, 3'b010);
        run_alu("slt", 7'b0110011, 3'b010, 1'b0, 3'b101);
        run_alu("ori", 7'b0010011, 3'b110, 1'b0, 3'b011);
        run_alu("addi_f7", 7'b0010011, 3'b000, 1'b1, 3'b000);

        // lw with three wait cycles in MEM_RD.
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc();  // DECODE
        cyc();  // MEM_ADR
        check("lw_adr_immsrc", ImmSrc, 3'b000);
        check("lw_adr_srca", ALUsrcA, 2'b10);
        check("lw_adr_ctrl", ALUctrl, 3'b000);
        mem_ready = 1'b0;
        cyc();  // MEM_RD
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("lw_rd_mem_req", mem_req, 1);
            check("lw_rd_adrsrc", AdrSrc, 1);
            check("lw_rd_we", mem_we, 0);
            check("lw_rd_nowr", RegWrite, 0);
            cyc();
        end
        check("lw_wb_regwrite", RegWrite, 1);
        check("lw_wb_ressrc", ResultSrc, 2'b01);
        check("lw_wb_retire", retire, 1);
        cyc();
        check("lw_fetch_nowr", RegWrite, 0);
        check("lw_fetch_adrsrc", AdrSrc, 0);

        // sw, zero-wait.
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc();
        cyc();  // MEM_ADR
        check("sw_adr_immsrc", ImmSrc, 3'b001);
        cyc();  // MEM_WR
        check("sw_wr_req", mem_req, 1);
        check("sw_wr_we", mem_we, 1);
        check("sw_wr_adrsrc", AdrSrc, 1);
        check("sw_wr_retire", retire, 1);
        cyc();
        check("sw_fetch_we", mem_we, 0);

        // beq taken, bne not taken, bne taken.
        Zero = 1'b1;
        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc();
        cyc();  // BRANCH
        check("beq_z1_pcwrite", PCWrite, 1);
        check("beq_ctrl", ALUctrl, 3'b001);
        check("beq_retire", retire, 1);
        cyc();
        set_instr(7'b1100011, 3'b001, 1'b0);
        cyc();
        cyc();
        check("bne_z1_pcwrite", PCWrite, 0);
        check("bne_retire", retire, 1);
        Zero = 1'b0;
        #1;
        check("bne_z0_pcwrite", PCWrite, 1);
        cyc();

        // JAL: link write first, then PC update.
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc();
        cyc();  // JAL
        check("jal_regwrite", RegWrite, 1);
        check("jal_pcwrite", PCWrite, 0);
        check("jal_srcb", ALUsrcB, 2'b10);
        cyc();  // JAL_PC
        check("jalpc_pcwrite", PCWrite, 1);
        check("jalpc_immsrc", ImmSrc, 3'b011);
        check("jalpc_retire", retire, 1);
        check("jalpc_regwrite", RegWrite, 0);
        cyc();

        // LUI
        set_instr(7'b0110111, 3'b000, 1'b0);
        cyc();
        cyc();
        check("lui_ctrl", ALUctrl, 3'b110);
        check("lui_immsrc", ImmSrc, 3'b100);
        check("lui_regwrite", RegWrite, 1);
        check("lui_retire", retire, 1);
        cyc();

        // FETCH timeout: four request cycles without mem_ready, then FAULT.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_mem_req", mem_req, 1);
            check("to_irwrite", IRWrite, 0);
            check("to_nofault", fault, 0);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            check("to_fault", fault, 1);
            check("to_fault_req", mem_req, 0);
            cyc();
        end
        mem_ready = 1'b1;
        check("to_fault_sticky", fault, 1);
        do_reset();
        check("to_after_rst_fault", fault, 0);
        check("to_after_rst_req", mem_req, 1);

        // Illegal opcode from DECODE.
        set_instr(7'b1110011, 3'b000, 1'b0);
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            check("ill_fault", fault, 1);
            check("ill_regwrite", RegWrite, 0);
            check("ill_pcwrite", PCWrite, 0);
            check("ill_mem_req", mem_req, 0);
            cyc();
        end
        do_reset();

        // rst mid-wait in MEM_WR drops the request and write strobe immediately.
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc();
        cyc();
        mem_ready = 1'b0;
        cyc();  // MEM_WR, waiting
        check("rstw_we_before", mem_we, 1);
        rst = 1'b1;
        #1;
        check("rstw_req", mem_req, 0);
        check("rstw_we", mem_we, 0);
        cyc();
        rst       = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rstw_fetch_req", mem_req, 1);
        check("rstw_fetch_adrsrc", AdrSrc, 0);

        // I-type funct3=101 is unsupported: EXEC_I goes to FAULT.
        set_instr(7'b0010011, 3'b101, 1'b0);
        cyc();
        cyc();  // EXEC_I
        cyc();
        check("srli_fault", fault, 1);
        check("srli_regwrite", RegWrite, 0);

        // Unsupported R-type funct7_5 combination.
        do_reset();
        set_instr(7'b0110011, 3'b110, 1'b1);
        cyc();
        cyc();
        cyc();
        check("rbad_fault", fault, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
